// File: rtl/wb_block_copier.sv
// wb_block_copier: Wishbone classic single-beat master that copies a block
// of 32-bit words from a source range to a destination range, one read then
// one write per word, with an idle bus cycle between transactions and a
// per-transaction ack timeout.
module wb_block_copier #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_start,
    input  logic [31:0]      cmd_src,
    input  logic [31:0]      cmd_dst,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_done,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_GAP_W = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_GAP_R = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    localparam int             TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [LEN_W-1:0] remaining;
    logic [31:0]      data_reg;
    logic [TMO_W-1:0] tmo_cnt;
    logic             in_xfer;
    logic             tmo_hit;
    logic             nxt_xfer;
    logic             nxt_busy;
    logic [31:0]      adr_nxt;

    assign in_xfer  = (state == S_RD) || (state == S_WR);
    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    assign nxt_xfer = (state_nxt == S_RD) || (state_nxt == S_WR);
    assign nxt_busy = (state_nxt == S_RD) || (state_nxt == S_GAP_W) ||
                      (state_nxt == S_WR) || (state_nxt == S_GAP_R);

    // Next-state decision: ack wins over a same-cycle timeout; zero-length
    // commands go straight to FIN so they still produce a done pulse.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_start) begin
                    state_nxt = (cmd_len != '0) ? S_RD : S_FIN;
                end
            end
            S_RD: begin
                if (wbm_ack_i) begin
                    state_nxt = S_GAP_W;
                end else if (tmo_hit) begin
                    state_nxt = S_FIN;
                end
            end
            S_GAP_W: state_nxt = S_WR;
            S_WR: begin
                if (wbm_ack_i) begin
                    state_nxt = (remaining == LEN_W'(1)) ? S_FIN : S_GAP_R;
                end else if (tmo_hit) begin
                    state_nxt = S_FIN;
                end
            end
            S_GAP_R: state_nxt = S_RD;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address presented in the coming bus cycle: a fresh copy reads straight
    // from the command, later reads use the advanced source pointer.
    always_comb begin
        adr_nxt = 32'h0;
        if (state_nxt == S_RD) begin
            adr_nxt = (state == S_IDLE) ? cmd_src : src_ptr;
        end else if (state_nxt == S_WR) begin
            adr_nxt = dst_ptr;
        end
    end

    // Control state, pointers, counters and the sticky timeout flag.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= S_IDLE;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            remaining  <= '0;
            data_reg   <= '0;
            tmo_cnt    <= '0;
            err        <= 1'b0;
            words_done <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= (in_xfer && (state_nxt == state)) ? tmo_cnt + TMO_W'(1) : '0;
            case (state)
                S_IDLE: begin
                    if (cmd_start && (cmd_len != '0)) begin
                        src_ptr    <= cmd_src;
                        dst_ptr    <= cmd_dst;
                        remaining  <= cmd_len;
                        err        <= 1'b0;
                        words_done <= '0;
                    end
                end
                S_RD: begin
                    if (wbm_ack_i) begin
                        data_reg <= wbm_dat_i;
                        src_ptr  <= src_ptr + 32'd4;
                    end else if (tmo_hit) begin
                        err <= 1'b1;
                    end
                end
                S_WR: begin
                    if (wbm_ack_i) begin
                        dst_ptr    <= dst_ptr + 32'd4;
                        words_done <= words_done + LEN_W'(1);
                        remaining  <= remaining - LEN_W'(1);
                    end else if (tmo_hit) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered bus and status outputs, derived from the state being entered
    // so stb/cyc fall on the very edge that samples ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= 32'h0;
            wbm_dat_o <= 32'h0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wbm_cyc_o <= nxt_xfer;
            wbm_stb_o <= nxt_xfer;
            wbm_we_o  <= (state_nxt == S_WR);
            wbm_sel_o <= nxt_xfer ? 4'hF : 4'h0;
            wbm_adr_o <= adr_nxt;
            wbm_dat_o <= (state_nxt == S_WR) ? data_reg : 32'h0;
            done      <= (state_nxt == S_FIN);
            busy      <= nxt_busy;
        end
    end

endmodule

// File: tb/tb_wb_block_copier.sv
// tb_wb_block_copier: directed bench for wb_block_copier with a Wishbone
// slave memory model and a transaction-level expectation queue.
module tb_wb_block_copier;

    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } txn_t;

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_i = 1'b1;
    logic             cmd_start = 1'b0;
    logic [31:0]      cmd_src = 32'h0;
    logic [31:0]      cmd_dst = 32'h0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             busy;
    logic             done;
    logic             err;
    logic [LEN_W-1:0] words_done;
    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [3:0]       wbm_sel_o;
    logic [31:0]      wbm_adr_o;
    logic [31:0]      wbm_dat_o;
    logic [31:0]      wbm_dat_i = 32'h0;
    logic             wbm_ack_i = 1'b0;

    txn_t        exp_q[$];
    logic [31:0] copy_q[$];
    int          runs[$];
    logic [31:0] mem [0:255];
    int          checks = 0;
    int          failures = 0;
    int          ack_latency = 1;
    int          ack_hold = 1;
    int          stall_read = -1;
    int          reads_served = 0;
    int          done_cnt = 0;
    int          txn_cnt = 0;
    bit          cyc_seen = 0;
    bit          busy_seen = 0;
    logic        first_stb = 1'b0;
    logic        first_busy = 1'b0;
    logic        first_err = 1'b0;

    wb_block_copier #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .cmd_start  (cmd_start),
        .cmd_src    (cmd_src),
        .cmd_dst    (cmd_dst),
        .cmd_len    (cmd_len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_done (words_done),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i)
    );

    // Free-running 100 MHz clock.
    always #5 wb_clk_i = ~wb_clk_i;

    function automatic int midx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    // Slave memory: samples the bus mid-cycle and answers on the next edge.
    task automatic slaveLoop();
        int wait_cnt = 0;
        int ack_left = 0;
        logic s_rst, s_cyc, s_stb, s_we;
        logic [31:0] s_adr, s_dat;
        forever begin
            @(negedge wb_clk_i);
            s_rst = wb_rst_i; s_cyc = wbm_cyc_o; s_stb = wbm_stb_o;
            s_we = wbm_we_o; s_adr = wbm_adr_o; s_dat = wbm_dat_o;
            @(posedge wb_clk_i);
            if (s_rst) begin
                wbm_ack_i <= 1'b0;
                wait_cnt = 0;
                ack_left = 0;
            end else if (ack_left > 0) begin
                ack_left--;
                if (ack_left == 0) wbm_ack_i <= 1'b0;
            end else if (s_cyc && s_stb) begin
                if (!s_we && reads_served == stall_read) begin
                    wait_cnt = 0;
                end else if (wait_cnt >= ack_latency - 1) begin
                    wbm_ack_i <= 1'b1;
                    ack_left = ack_hold;
                    wait_cnt = 0;
                    if (s_we) begin
                        mem[midx(s_adr)] = s_dat;
                    end else begin
                        wbm_dat_i <= mem[midx(s_adr)];
                        reads_served++;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    endtask

    // Per-cycle compare: each new strobe must be the next expected transaction.
    task automatic compareLoop();
        logic prev_stb = 1'b0;
        int   run = 0;
        txn_t t;
        forever begin
            @(negedge wb_clk_i);
            if (wb_rst_i) begin
                prev_stb = 1'b0;
                run = 0;
            end else begin
                if (done) done_cnt++;
                if (wbm_cyc_o) cyc_seen = 1;
                if (busy) busy_seen = 1;
                checkOutput("sel_lanes", 32'(wbm_sel_o), wbm_cyc_o ? 32'hF : 32'h0);
                if (wbm_stb_o && !prev_stb) begin
                    txn_cnt++;
                    run = 1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_txn: got we=%0b adr=0x%08h, required no transaction", wbm_we_o, wbm_adr_o);
                    end else begin
                        t = exp_q.pop_front();
                        checkOutput("txn_we", 32'(wbm_we_o), 32'(t.we));
                        checkOutput("txn_adr", wbm_adr_o, t.adr);
                        if (t.we) checkOutput("txn_dat", wbm_dat_o, t.dat);
                    end
                end else if (wbm_stb_o) begin
                    run++;
                end
                if (!wbm_stb_o && prev_stb) runs.push_back(run);
                prev_stb = wbm_stb_o;
            end
        end
    endtask

    // Model: the read/write sequence a copy must produce, truncated at a
    // read that never gets acked.
    task automatic buildCopy(input logic [31:0] src, input logic [31:0] dst, input int len, input int stall);
        txn_t r, w;
        exp_q.delete();
        copy_q.delete();
        for (int i = 0; i < len; i++) begin
            r.we = 1'b0; r.adr = src + 32'(4 * i); r.dat = 32'h0;
            exp_q.push_back(r);
            if (i == stall) break;
            w.we = 1'b1; w.adr = dst + 32'(4 * i); w.dat = mem[midx(r.adr)];
            exp_q.push_back(w);
            copy_q.push_back(w.dat);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input int len);
        @(negedge wb_clk_i);
        cmd_src = src;
        cmd_dst = dst;
        cmd_len = LEN_W'(len);
        cmd_start = 1'b1;
    endtask

    task automatic waitDone(input int bound, input int inject_at, output int n_done);
        bit seen = 0;
        n_done = -1;
        for (int n = 1; n <= bound && !seen; n++) begin
            @(negedge wb_clk_i);
            cmd_start = (n == inject_at);
            if (n == inject_at) begin
                cmd_src = 32'h3800_0100;
                cmd_dst = 32'h3800_0140;
                cmd_len = LEN_W'(7);
            end
            if (n == 1) begin
                first_stb = wbm_stb_o;
                first_busy = busy;
                first_err = err;
            end
            if (done) begin
                seen = 1;
                n_done = n;
                checkOutput("busy_low_with_done", 32'(busy), 32'h0);
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout: no done pulse within %0d cycles, required one", bound);
        end
    endtask

    task automatic runCopy(input logic [31:0] src, input logic [31:0] dst, input int len, input int stall,
                           input int inject_at, input int exp_n, input logic exp_err, input int exp_wd);
        int n_done;
        for (int i = 0; i < len; i++) mem[midx(dst + 32'(4 * i))] = 32'h0;
        done_cnt = 0; txn_cnt = 0; cyc_seen = 0; busy_seen = 0;
        reads_served = 0; stall_read = stall;
        runs.delete();
        buildCopy(src, dst, len, stall);
        applyStimulus(src, dst, len);
        waitDone(300, inject_at, n_done);
        checkOutput("cycles_to_done", 32'(n_done), 32'(exp_n));
        repeat (3) @(negedge wb_clk_i);
        checkOutput("done_pulses", 32'(done_cnt), 32'd1);
        checkOutput("err", 32'(err), 32'(exp_err));
        checkOutput("busy_after", 32'(busy), 32'h0);
        if (exp_wd >= 0) checkOutput("words_done", 32'(words_done), 32'(exp_wd));
        checkOutput("txns_left", 32'(exp_q.size()), 32'h0);
        checkOutput("first_stb", 32'(first_stb), 32'(len != 0));
        checkOutput("first_busy", 32'(first_busy), 32'(len != 0));
        if (len != 0) checkOutput("err_cleared_on_start", 32'(first_err), 32'h0);
        for (int i = 0; i < copy_q.size(); i++)
            checkOutput("dst_word", mem[midx(dst + 32'(4 * i))], copy_q[i]);
        stall_read = -1;
    endtask

    // Directed scenario sequence.
    initial begin
        bit found;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        fork
            slaveLoop();
            compareLoop();
        join_none

        repeat (3) @(negedge wb_clk_i);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        checkOutput("rst_words_done", 32'(words_done), 32'h0);
        checkOutput("rst_cyc", 32'(wbm_cyc_o), 32'h0);
        checkOutput("rst_stb", 32'(wbm_stb_o), 32'h0);
        wb_rst_i = 1'b0;

        $display("[TB] basic copy, ack after 1 cycle");
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
        ack_latency = 1; ack_hold = 1;
        runCopy(32'h3800_0000, 32'h3800_0040, 3, -1, 0, 18, 1'b0, 3);
        checkOutput("lit_dst0", mem[16], 32'h11);
        checkOutput("lit_dst2", mem[18], 32'h33);
        checkOutput("lit_runs", 32'(runs.size()), 32'd6);
        if (runs.size() == 6) checkOutput("lit_run_len", 32'(runs[5]), 32'd2);

        $display("[TB] slow slave, ack after 11 cycles held 2");
        mem[4] = 32'hCAFE_0001; mem[5] = 32'hCAFE_0002;
        ack_latency = 11; ack_hold = 2;
        runCopy(32'h3800_0010, 32'h3800_0060, 2, -1, 0, 52, 1'b0, 2);
        checkOutput("lit_txn_cnt", 32'(txn_cnt), 32'd4);
        for (int i = 0; i < runs.size(); i++) checkOutput("lit_slow_run", 32'(runs[i]), 32'd12);

        $display("[TB] zero length command");
        ack_latency = 1; ack_hold = 1;
        runCopy(32'h3800_0000, 32'h3800_0040, 0, -1, 0, 1, 1'b0, -1);
        checkOutput("len0_no_cyc", 32'(cyc_seen), 32'h0);
        checkOutput("len0_no_busy", 32'(busy_seen), 32'h0);

        $display("[TB] timeout on second read");
        mem[3] = 32'h44;
        runCopy(32'h3800_0000, 32'h3800_0080, 4, 1, 0, 71, 1'b1, 1);
        checkOutput("lit_tmo_runs", 32'(runs.size()), 32'd3);
        if (runs.size() == 3) checkOutput("lit_tmo_stb_len", 32'(runs[2]), 32'd64);
        runCopy(32'h3800_0000, 32'h3800_00A0, 1, -1, 0, 6, 1'b0, 1);

        $display("[TB] start while busy is ignored");
        runCopy(32'h3800_0000, 32'h3800_0040, 3, -1, 5, 18, 1'b0, 3);

        $display("[TB] reset during write");
        ack_latency = 3;
        done_cnt = 0;
        buildCopy(32'h3800_0000, 32'h3800_00C0, 2, -1);
        applyStimulus(32'h3800_0000, 32'h3800_00C0, 2);
        found = 0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge wb_clk_i);
            cmd_start = 1'b0;
            if (wbm_stb_o && wbm_we_o) found = 1;
        end
        checkOutput("reached_write", 32'(found), 32'h1);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        checkOutput("rst_mid_cyc", 32'(wbm_cyc_o), 32'h0);
        checkOutput("rst_mid_stb", 32'(wbm_stb_o), 32'h0);
        checkOutput("rst_mid_we", 32'(wbm_we_o), 32'h0);
        checkOutput("rst_mid_busy", 32'(busy), 32'h0);
        checkOutput("rst_mid_done", 32'(done), 32'h0);
        wb_rst_i = 1'b0;
        exp_q.delete();
        repeat (4) @(negedge wb_clk_i);
        checkOutput("rst_mid_no_done", 32'(done_cnt), 32'h0);
        checkOutput("rst_mid_words_done", 32'(words_done), 32'h0);
        ack_latency = 1;
        runCopy(32'h3800_0004, 32'h3800_00C0, 1, -1, 0, 6, 1'b0, 1);

        $display("[TB] source address wrap");
        mem[255] = 32'hA5A5_0001; mem[0] = 32'h5A5A_0002;
        runCopy(32'hFFFF_FFFC, 32'h3800_0080, 2, -1, 0, 12, 1'b0, 2);
        checkOutput("lit_wrap_dst1", mem[33], 32'h5A5A_0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
